// File: rtl/adxl362_spi_master_if.sv
// Control-side handshake between the system controller and the ADXL362 SPI master.
// The controller uses the master modport; the SPI engine uses the slave modport.
interface adxl362_spi_master_if;
  logic        start;
  logic [1:0]  op;
  logic [5:0]  address;
  logic [7:0]  data_write;
  logic [15:0] data_read;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, op, address, data_write,
    input  data_read, busy, done, error
  );

  modport slave (
    input  start, op, address, data_write,
    output data_read, busy, done, error
  );
endinterface

// File: rtl/adxl362_spi_master.sv
// SPI mode-0 master for the ADXL362: one 3-byte frame per accepted start
// (register write, register read or FIFO read), with setup/hold/deselect timing of CLK_DIV cycles.
module adxl362_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                       clk_sys,
  input  logic                       rst,
  adxl362_spi_master_if.slave        ctrl,
  output logic                       SCLK,
  output logic                       MOSI,
  input  logic                       MISO,
  output logic                       nCS
);

  localparam int unsigned     CntW    = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      bit_q;
  logic [23:0]     tx_q;
  logic [15:0]     rx_q;
  logic [1:0]      op_q;
  logic [23:0]     frame;
  logic            cnt_end;

  assign cnt_end = (cnt_q == CntLast);

  always_comb begin
    frame = 24'h000000;
    unique case (ctrl.op)
      2'd0:    frame = {8'h0A, 2'b00, ctrl.address, ctrl.data_write};
      2'd1:    frame = {8'h0B, 2'b00, ctrl.address, 8'h00};
      2'd2:    frame = {8'h0D, 16'h0000};
      default: frame = 24'h000000;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      bit_q          <= 5'd0;
      tx_q           <= 24'h000000;
      rx_q           <= 16'h0000;
      op_q           <= 2'd0;
      SCLK           <= 1'b0;
      MOSI           <= 1'b0;
      nCS            <= 1'b1;
      ctrl.busy      <= 1'b0;
      ctrl.done      <= 1'b0;
      ctrl.error     <= 1'b0;
      ctrl.data_read <= 16'h0000;
    end else begin
      ctrl.done  <= 1'b0;
      ctrl.error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A start coinciding with the done pulse is dropped, not queued.
          if (ctrl.start && !ctrl.done) begin
            if (ctrl.op == 2'd3) begin
              ctrl.done  <= 1'b1;
              ctrl.error <= 1'b1;
            end else begin
              op_q      <= ctrl.op;
              tx_q      <= frame;
              MOSI      <= frame[23];
              nCS       <= 1'b0;
              ctrl.busy <= 1'b1;
              cnt_q     <= '0;
              state_q   <= StSetup;
            end
          end
        end
        StSetup: begin
          if (cnt_end) begin
            cnt_q   <= '0;
            SCLK    <= 1'b1;
            rx_q    <= {rx_q[14:0], MISO};
            bit_q   <= 5'd23;
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StShift: begin
          if (!cnt_end) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (SCLK) begin
              SCLK <= 1'b0;
              if (bit_q == 5'd0) begin
                MOSI    <= 1'b0;
                state_q <= StHold;
              end else begin
                bit_q <= bit_q - 5'd1;
                tx_q  <= {tx_q[22:0], 1'b0};
                MOSI  <= tx_q[22];
              end
            end else begin
              SCLK <= 1'b1;
              rx_q <= {rx_q[14:0], MISO};
            end
          end
        end
        StHold: begin
          if (cnt_end) begin
            cnt_q   <= '0;
            nCS     <= 1'b1;
            state_q <= StGap;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_end) begin
            cnt_q     <= '0;
            ctrl.done <= 1'b1;
            ctrl.busy <= 1'b0;
            // rx_q holds bytes 2 and 3; the FIFO sends its low byte first.
            if (op_q == 2'd1) ctrl.data_read <= {8'h00, rx_q[7:0]};
            else if (op_q == 2'd2) ctrl.data_read <= {rx_q[7:0], rx_q[15:8]};
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adxl362_spi_master.sv
// Directed bench for adxl362_spi_master: two instances (CLK_DIV=4 and CLK_DIV=1), each paired
// with a small ADXL362-like slave model (register file plus one FIFO word).
module tb_adxl362_spi_master;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_sys = ~clk_sys;

  adxl362_spi_master_if bus4 ();
  adxl362_spi_master_if bus1 ();

  logic sclk4, mosi4, ncs4, miso4;
  logic sclk1, mosi1, ncs1, miso1;

  adxl362_spi_master #(.CLK_DIV(4)) dut4 (
    .clk_sys (clk_sys),
    .rst     (rst),
    .ctrl    (bus4.slave),
    .SCLK    (sclk4),
    .MOSI    (mosi4),
    .MISO    (miso4),
    .nCS     (ncs4)
  );

  adxl362_spi_master #(.CLK_DIV(1)) dut1 (
    .clk_sys (clk_sys),
    .rst     (rst),
    .ctrl    (bus1.slave),
    .SCLK    (sclk1),
    .MOSI    (mosi1),
    .MISO    (miso1),
    .nCS     (ncs1)
  );

  // Slave model state, index 0 -> dut4, index 1 -> dut1.
  logic [1:0]  sclk_v, ncs_v, mosi_v, miso_v;
  logic [1:0]  sclk_p = 2'b00;
  logic [1:0]  ncs_p  = 2'b11;
  int          nbits      [2] = '{default: 0};
  int          rises      [2] = '{default: 0};
  int          fifo_reads [2] = '{default: 0};
  int          sclk_tog   [2] = '{default: 0};
  int          ncs_tog    [2] = '{default: 0};
  logic [23:0] frame_in   [2] = '{default: 24'h0};
  logic [7:0]  cmd_q      [2] = '{default: 8'h0};
  logic [7:0]  addr_q     [2] = '{default: 8'h0};
  logic [7:0]  regs       [2][64] = '{'{0: 8'hAD, default: 8'h00}, '{0: 8'hAD, default: 8'h00}};
  logic [15:0] fifo_word  [2];

  assign sclk_v = {sclk1, sclk4};
  assign ncs_v  = {ncs1, ncs4};
  assign mosi_v = {mosi1, mosi4};
  assign miso4  = miso_v[0];
  assign miso1  = miso_v[1];

  always @(negedge clk_sys) begin
    int b;
    int bp;
    logic [7:0] ob;
    for (int i = 0; i < 2; i++) begin
      if (ncs_v[i]) begin
        nbits[i] = 0;
      end else if (sclk_v[i] && !sclk_p[i]) begin
        frame_in[i] = ((nbits[i] == 0) ? 24'h0 : (frame_in[i] << 1)) | {23'h0, mosi_v[i]};
        nbits[i]    = nbits[i] + 1;
        rises[i]    = rises[i] + 1;
        if (nbits[i] == 8) begin
          cmd_q[i] = frame_in[i][7:0];
          if (cmd_q[i] == 8'h0D) fifo_reads[i] = fifo_reads[i] + 1;
        end
        if (nbits[i] == 16) addr_q[i] = frame_in[i][7:0];
        if (nbits[i] == 24 && cmd_q[i] == 8'h0A) regs[i][addr_q[i][5:0]] = frame_in[i][7:0];
      end
      if (sclk_v[i] != sclk_p[i]) sclk_tog[i] = sclk_tog[i] + 1;
      if (ncs_v[i] != ncs_p[i]) ncs_tog[i] = ncs_tog[i] + 1;
      sclk_p[i] = sclk_v[i];
      ncs_p[i]  = ncs_v[i];
      b  = nbits[i] / 8;
      bp = 7 - (nbits[i] % 8);
      ob = 8'h00;
      if (b == 1 && cmd_q[i] == 8'h0D) ob = fifo_word[i][7:0];
      if (b == 2 && cmd_q[i] == 8'h0D) ob = fifo_word[i][15:8];
      if (b == 2 && cmd_q[i] == 8'h0B) ob = regs[i][addr_q[i][5:0]];
      miso_v[i] = (b < 3) ? ob[bp] : 1'b0;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic set_req(input int inst, input logic s, input logic [1:0] op,
                         input logic [5:0] a, input logic [7:0] d);
    if (inst == 0) begin
      bus4.start = s; bus4.op = op; bus4.address = a; bus4.data_write = d;
    end else begin
      bus1.start = s; bus1.op = op; bus1.address = a; bus1.data_write = d;
    end
  endtask

  function automatic logic get_done(input int inst);
    return (inst == 0) ? bus4.done : bus1.done;
  endfunction

  function automatic logic get_err(input int inst);
    return (inst == 0) ? bus4.error : bus1.error;
  endfunction

  function automatic logic get_ncs(input int inst);
    return (inst == 0) ? ncs4 : ncs1;
  endfunction

  // k counts cycles after the accepting edge: k=1 is the first cycle showing registered results.
  task automatic run_op(input int inst, input logic [1:0] op, input logic [5:0] a,
                        input logic [7:0] d, input int restart_k,
                        output int lat, output int ncs_hi, output int ndone, output logic err);
    int k;
    tick();
    set_req(inst, 1'b1, op, a, d);
    tick();
    set_req(inst, 1'b0, op, a, d);
    k = 1; lat = -1; ncs_hi = -1; ndone = 0; err = 1'b0;
    while (k < 400) begin
      if (k == restart_k) set_req(inst, 1'b1, 2'd1, 6'h3F, 8'hFF);
      else if (k == restart_k + 1) set_req(inst, 1'b0, 2'd1, 6'h3F, 8'hFF);
      if (get_done(inst)) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          err = get_err(inst);
        end
      end
      if (get_ncs(inst) && ncs_hi < 0 && lat < 0) ncs_hi = k;
      if (lat >= 0 && k >= lat + 20) break;
      tick();
      k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ncs_hi, ndone, r0, f0, t0, c0, k;
    logic err;
    fifo_word[0] = 16'h1234;
    fifo_word[1] = 16'h0000;
    set_req(0, 1'b0, 2'd0, 6'h00, 8'h00);
    set_req(1, 1'b0, 2'd0, 6'h00, 8'h00);
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ncs", 32'(ncs4), 32'd1);
    chk("rst_sclk", 32'(sclk4), 32'd0);
    chk("rst_mosi", 32'(mosi4), 32'd0);
    chk("rst_busy_done_err", {29'd0, bus4.busy, bus4.done, bus4.error}, 32'd0);
    chk("rst_data_read", 32'(bus4.data_read), 32'h0000);
    rst = 1'b0;
    tick();

    // 1: register write
    r0 = rises[0];
    run_op(0, 2'd0, 6'h2D, 8'h02, -1, lat, ncs_hi, ndone, err);
    chk("t1_done_lat", 32'(lat), 32'd201);
    chk("t1_ncs_high", 32'(ncs_hi), 32'd197);
    chk("t1_rises", 32'(rises[0] - r0), 32'd24);
    chk("t1_mosi_frame", 32'(frame_in[0]), 32'h0A2D02);
    chk("t1_slave_reg", 32'(regs[0][45]), 32'h02);
    chk("t1_ndone_err", {ndone[30:0], err}, {31'd1, 1'b0});
    chk("t1_busy_after", 32'(bus4.busy), 32'd0);

    // 2: register read
    run_op(0, 2'd1, 6'h00, 8'h55, -1, lat, ncs_hi, ndone, err);
    chk("t2_done_lat", 32'(lat), 32'd201);
    chk("t2_data_read", 32'(bus4.data_read), 32'h00AD);
    chk("t2_mosi_frame", 32'(frame_in[0]), 32'h0B0000);

    // 3: FIFO read
    f0 = fifo_reads[0];
    run_op(0, 2'd2, 6'h11, 8'h22, -1, lat, ncs_hi, ndone, err);
    chk("t3_data_read", 32'(bus4.data_read), 32'h1234);
    chk("t3_fifo_pulses", 32'(fifo_reads[0] - f0), 32'd1);
    chk("t3_mosi_frame", 32'(frame_in[0]), 32'h0D0000);

    // 4: start (with different op/address) while busy is ignored
    r0 = rises[0];
    run_op(0, 2'd0, 6'h05, 8'h77, 10, lat, ncs_hi, ndone, err);
    chk("t4_rises", 32'(rises[0] - r0), 32'd24);
    chk("t4_done_lat", 32'(lat), 32'd201);
    chk("t4_ndone", 32'(ndone), 32'd1);
    chk("t4_mosi_frame", 32'(frame_in[0]), 32'h0A0577);
    chk("t4_slave_reg", 32'(regs[0][5]), 32'h77);
    chk("t4_data_read_held", 32'(bus4.data_read), 32'h1234);

    // 5: reset at the 12th SCLK rise, then a clean read
    r0 = rises[0];
    tick();
    set_req(0, 1'b1, 2'd1, 6'h00, 8'h00);
    tick();
    set_req(0, 1'b0, 2'd1, 6'h00, 8'h00);
    k = 0;
    while ((rises[0] - r0) < 12 && k < 500) begin
      tick();
      k++;
    end
    chk("t5_reached_rise12", 32'(rises[0] - r0), 32'd12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ncs", 32'(ncs4), 32'd1);
    chk("t5_sclk_mosi", {30'd0, sclk4, mosi4}, 32'd0);
    chk("t5_busy", 32'(bus4.busy), 32'd0);
    ndone = 0;
    repeat (300) begin
      tick();
      if (bus4.done) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);
    run_op(0, 2'd1, 6'h2D, 8'h00, -1, lat, ncs_hi, ndone, err);
    chk("t5_read_lat", 32'(lat), 32'd201);
    chk("t5_read_data", 32'(bus4.data_read), 32'h0002);

    // 6: invalid op
    t0 = sclk_tog[0];
    c0 = ncs_tog[0];
    run_op(0, 2'd3, 6'h01, 8'h01, -1, lat, ncs_hi, ndone, err);
    chk("t6_done_lat", 32'(lat), 32'd1);
    chk("t6_error", 32'(err), 32'd1);
    chk("t6_ndone", 32'(ndone), 32'd1);
    chk("t6_no_toggle", 32'((sclk_tog[0] - t0) + (ncs_tog[0] - c0)), 32'd0);
    chk("t6_data_read_held", 32'(bus4.data_read), 32'h0002);

    // 7: register read with CLK_DIV=1
    run_op(1, 2'd1, 6'h00, 8'h00, -1, lat, ncs_hi, ndone, err);
    chk("t7_done_lat", 32'(lat), 32'd51);
    chk("t7_ncs_high", 32'(ncs_hi), 32'd50);
    chk("t7_data_read", 32'(bus1.data_read), 32'h00AD);
    chk("t7_mosi_frame", 32'(frame_in[1]), 32'h0B0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
